// File: rtl/dds_param_ctrl.sv
// DDS parameter controller: three debounced push-buttons select and step the
// coarse/fine frequency words and the phase word of a DDS core.
module dds_param_ctrl #(
   parameter int unsigned DB_CYCLES = 1000000,
   parameter logic [5:0]  F1_INIT   = 6'd1,
   parameter logic [7:0]  F2_INIT   = 8'd0,
   parameter logic [8:0]  P_INIT    = 9'd0
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_sel,
   input  logic       key_up,
   input  logic       key_down,
   output logic [5:0] Fword1,
   output logic [7:0] Fword2,
   output logic [8:0] Pword2,
   output logic [1:0] edit_field,
   output logic       param_upd
);

   localparam int unsigned NK = 3;
   localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

   // Key index: 0 = sel, 1 = up, 2 = down
   localparam int unsigned K_SEL  = 0;
   localparam int unsigned K_UP   = 1;
   localparam int unsigned K_DOWN = 2;

   typedef enum logic [1:0] {
      EDIT_F1 = 2'b00,
      EDIT_F2 = 2'b01,
      EDIT_P  = 2'b10
   } state_e;

   logic [NK-1:0]         keys_raw;
   logic [NK-1:0]         sync1_q, sync2_q;
   logic [NK-1:0]         db_q, db_d;
   logic [NK-1:0]         db_dly_q;
   logic [NK-1:0]         press_q, press_d;
   logic [NK-1:0][CW-1:0] cnt_q, cnt_d;

   state_e     state_q, state_d;
   logic [5:0] f1_q, f1_d;
   logic [7:0] f2_q, f2_d;
   logic [8:0] p_q, p_d;
   logic       upd_q, upd_d;

   logic sel_p, up_p, dn_p;

   assign keys_raw = {key_down, key_up, key_sel};

   // Debounce: accept a new level after DB_CYCLES consecutive differing cycles
   always_comb begin
      db_d  = db_q;
      cnt_d = cnt_q;
      for (int k = 0; k < NK; k++) begin
         if (sync2_q[k] == db_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CW'(DB_CYCLES - 1)) begin
            db_d[k]  = sync2_q[k];
            cnt_d[k] = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
         end
      end
   end

   // Rising edge of the debounced level only; releases produce nothing
   assign press_d = db_q & ~db_dly_q;

   assign sel_p = press_q[K_SEL];
   assign up_p  = press_q[K_UP];
   assign dn_p  = press_q[K_DOWN];

   // Edit FSM and word update; sel wins over up/down, up+down cancels
   always_comb begin
      state_d = state_q;
      f1_d    = f1_q;
      f2_d    = f2_q;
      p_d     = p_q;
      upd_d   = 1'b0;
      if (sel_p) begin
         case (state_q)
            EDIT_F1: state_d = EDIT_F2;
            EDIT_F2: state_d = EDIT_P;
            default: state_d = EDIT_F1;
         endcase
      end else if (up_p ^ dn_p) begin
         upd_d = 1'b1;
         case (state_q)
            EDIT_F1: f1_d = up_p ? (f1_q + 6'd1) : (f1_q - 6'd1);
            EDIT_F2: f2_d = up_p ? (f2_q + 8'd1) : (f2_q - 8'd1);
            EDIT_P:  p_d  = up_p ? (p_q + 9'd1)  : (p_q - 9'd1);
            default: upd_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         db_dly_q <= '0;
         cnt_q    <= '0;
         press_q  <= '0;
         state_q  <= EDIT_F1;
         f1_q     <= F1_INIT;
         f2_q     <= F2_INIT;
         p_q      <= P_INIT;
         upd_q    <= 1'b0;
      end else begin
         sync1_q  <= keys_raw;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         state_q  <= state_d;
         f1_q     <= f1_d;
         f2_q     <= f2_d;
         p_q      <= p_d;
         upd_q    <= upd_d;
      end
   end

   assign Fword1     = f1_q;
   assign Fword2     = f2_q;
   assign Pword2     = p_q;
   assign edit_field = state_q;
   assign param_upd  = upd_q;

endmodule

// File: tb/tb_dds_param_ctrl.sv
// Bench for dds_param_ctrl: a button-level model feeds a scoreboard of
// expected word updates, checked whenever the DUT strobes param_upd.
module tb_dds_param_ctrl;

   localparam int unsigned DB  = 4;
   localparam int unsigned GAP = 2 * DB + 8;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       key_sel, key_up, key_down;
   logic [5:0] Fword1;
   logic [7:0] Fword2;
   logic [8:0] Pword2;
   logic [1:0] edit_field;
   logic       param_upd;

   int vectors     = 0;
   int miscompares = 0;

   int m_word[3];
   int m_mod[3] = '{64, 256, 512};
   int m_field;
   logic [22:0] sb[$];

   dds_param_ctrl #(
      .DB_CYCLES(DB),
      .F1_INIT  (6'd1),
      .F2_INIT  (8'd0),
      .P_INIT   (9'd0)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .key_sel   (key_sel),
      .key_up    (key_up),
      .key_down  (key_down),
      .Fword1    (Fword1),
      .Fword2    (Fword2),
      .Pword2    (Pword2),
      .edit_field(edit_field),
      .param_upd (param_upd)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [22:0] exp_words();
      return {6'(m_word[0]), 8'(m_word[1]), 9'(m_word[2])};
   endfunction

   function automatic void model_reset();
      m_word[0] = 1;
      m_word[1] = 0;
      m_word[2] = 0;
      m_field   = 0;
   endfunction

   // One accepted button event: sel cycles the field, a lone up/down steps the word
   function automatic void model_press(input bit s, input bit u, input bit d);
      if (s) begin
         m_field = (m_field + 1) % 3;
      end else if (u != d) begin
         m_word[m_field] = (m_word[m_field] + (u ? 1 : m_mod[m_field] - 1)) % m_mod[m_field];
         sb.push_back(exp_words());
      end
   endfunction

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".Fword1"}, int'(Fword1), m_word[0]);
      check({tag, ".Fword2"}, int'(Fword2), m_word[1]);
      check({tag, ".Pword2"}, int'(Pword2), m_word[2]);
      check({tag, ".edit_field"}, int'(edit_field), m_field);
   endtask

   // Hold a key combination for `hold` cycles; it counts only if stable for DB cycles
   task automatic press(input string tag, input bit s, input bit u, input bit d, input int hold);
      if (hold >= DB) model_press(s, u, d);
      key_sel  = s;
      key_up   = u;
      key_down = d;
      wait_cyc(hold);
      key_sel  = 1'b0;
      key_up   = 1'b0;
      key_down = 1'b0;
      wait_cyc(GAP);
      check_state(tag);
   endtask

   // Cycles from the current point until param_upd is seen, or -1 on timeout
   task automatic upd_latency(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge sys_clk);
         #1;
         if (param_upd) begin
            n = i;
            break;
         end
      end
   endtask

   // Scoreboard monitor
   always @(negedge sys_clk) begin
      logic [22:0] exp_w;
      if (!sys_rst && param_upd) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL upd_strobe: unexpected param_upd with F1=%0d F2=%0d P=%0d, expected none (t=%0t)",
                     Fword1, Fword2, Pword2, $time);
         end else begin
            exp_w = sb.pop_front();
            if ({Fword1, Fword2, Pword2} !== exp_w) begin
               miscompares++;
               $display("FAIL upd_words: got F1=%0d F2=%0d P=%0d expected F1=%0d F2=%0d P=%0d (t=%0t)",
                        Fword1, Fword2, Pword2, exp_w[22:17], exp_w[16:9], exp_w[8:0], $time);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit s, u, d;
      int hold;

      sys_rst  = 1'b1;
      key_sel  = 1'b0;
      key_up   = 1'b0;
      key_down = 1'b0;
      model_reset();
      wait_cyc(3);
      check_state("reset");
      check("reset.param_upd", int'(param_upd), 0);
      sys_rst = 1'b0;
      wait_cyc(2);

      // Held key: one increment, word appears DB+4 cycles after the raw edge
      model_press(1'b0, 1'b1, 1'b0);
      key_up = 1'b1;
      upd_latency(n);
      check("held_up.latency", n, DB + 4);
      wait_cyc(12);
      key_up = 1'b0;
      wait_cyc(GAP);
      check_state("held_up");

      // Bounce: 2-cycle toggles never reach the debounce threshold
      for (int i = 0; i < 15; i++) begin
         key_up = (i % 2 == 0);
         wait_cyc(2);
      end
      key_up = 1'b0;
      wait_cyc(GAP);
      check_state("bounce");

      // Debounce threshold boundary
      press("short_hold", 1'b0, 1'b1, 1'b0, DB - 1);
      press("exact_hold", 1'b0, 1'b1, 1'b0, DB);

      // Phase word wrap in both directions
      press("sel1", 1'b1, 1'b0, 1'b0, DB + 2);
      press("sel2", 1'b1, 1'b0, 1'b0, DB + 2);
      press("p_dn_wrap", 1'b0, 1'b0, 1'b1, DB + 2);
      press("p_up_wrap", 1'b0, 1'b1, 1'b0, DB + 2);
      press("p_dn_wrap2", 1'b0, 1'b0, 1'b1, DB + 2);

      // Fine word wrap and up+down cancellation
      press("sel3", 1'b1, 1'b0, 1'b0, DB + 2);
      press("sel4", 1'b1, 1'b0, 1'b0, DB + 2);
      press("f2_dn_wrap", 1'b0, 1'b0, 1'b1, DB + 2);
      press("f2_updn", 1'b0, 1'b1, 1'b1, DB + 2);
      press("f2_up_wrap", 1'b0, 1'b1, 1'b0, DB + 2);

      // Coarse word down to zero and wrap
      press("sel5", 1'b1, 1'b0, 1'b0, DB + 2);
      press("sel6", 1'b1, 1'b0, 1'b0, DB + 2);
      for (int i = 0; i < 3; i++) press("f1_dn", 1'b0, 1'b0, 1'b1, DB + 1);
      press("f1_dn_wrap", 1'b0, 1'b0, 1'b1, DB + 2);
      press("f1_up_wrap", 1'b0, 1'b1, 1'b0, DB + 2);

      // sel together with up: field advances, no word change
      press("sel_up", 1'b1, 1'b1, 1'b0, DB + 2);

      for (int i = 0; i < 60; i++) begin
         s    = bit'($urandom_range(0, 1));
         u    = bit'($urandom_range(0, 1));
         d    = bit'($urandom_range(0, 1));
         hold = int'($urandom_range(1, DB + 6));
         press("rand", s, u, d, hold);
      end

      // Reset during a debounce with the key held throughout
      key_up = 1'b1;
      wait_cyc(4);
      sys_rst = 1'b1;
      sb.delete();
      model_reset();
      wait_cyc(1);
      check_state("mid_reset");
      check("mid_reset.param_upd", int'(param_upd), 0);
      wait_cyc(1);
      sys_rst = 1'b0;
      model_press(1'b0, 1'b1, 1'b0);
      // Press pulse DB+2 cycles after the first un-reset edge, word one cycle later
      upd_latency(n);
      check("reset_hold.latency", n, DB + 4);
      wait_cyc(10);
      key_up = 1'b0;
      wait_cyc(GAP);
      check_state("reset_hold");

      wait_cyc(5);
      check("pending_updates", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dds_param_ctrl.md
DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive stable cycles required to accept a key level (20 ms at 50 MHz).
REQ-002 SHALL have parameter F1_INIT, default 6'd1, meaning the Fword1 reset value.
REQ-003 SHALL have parameter F2_INIT, default 8'd0, meaning the Fword2 reset value.
REQ-004 SHALL have parameter P_INIT, default 9'd0, meaning the Pword2 reset value.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port key_sel, input, 1 bit: raw field-select button, active-high, asynchronous to sys_clk.
REQ-008 SHALL have port key_up, input, 1 bit: raw increment button, active-high, asynchronous to sys_clk.
REQ-009 SHALL have port key_down, input, 1 bit: raw decrement button, active-high, asynchronous to sys_clk.
REQ-010 SHALL have port Fword1, output, 6 bits: coarse frequency word, registered.
REQ-011 SHALL have port Fword2, output, 8 bits: fine frequency word, registered.
REQ-012 SHALL have port Pword2, output, 9 bits: phase word, registered.
REQ-013 SHALL have port edit_field, output, 2 bits: field under edit (00=F1, 01=F2, 10=P), registered.
REQ-014 SHALL have port param_upd, output, 1 bit: one-cycle strobe issued when any word changes.

Function
REQ-015 SHALL pass each key through a 2-flop synchronizer before any other use.
REQ-016 SHALL keep, per key, a debounced level and a counter; the counter clears whenever the synchronized level equals the debounced level.
REQ-017 SHALL update the debounced level and clear the counter once the synchronized level has differed from it for exactly DB_CYCLES consecutive cycles.
REQ-018 SHALL generate a one-cycle press pulse on each debounced 0->1 transition, and no pulse on release.
REQ-019 SHALL implement an edit FSM with states EDIT_F1, EDIT_F2 and EDIT_P; edit_field SHALL encode the current state.
REQ-020 SHALL advance the FSM on a sel pulse: EDIT_F1->EDIT_F2->EDIT_P->EDIT_F1; with no sel pulse the state SHALL hold.
REQ-021 SHALL, on an up pulse, increment only the word selected by the current state, modulo its width (F1 63->0, F2 255->0, P 511->0).
REQ-022 SHALL, on a down pulse, decrement only the selected word, modulo its width (F1 0->63, F2 0->255, P 0->511).
REQ-023 SHALL NOT change any word when up and down pulses occur in the same cycle.
REQ-024 SHALL, when a sel pulse coincides with up or down, advance the field and ignore up/down in that cycle.
REQ-025 SHALL update a word in the cycle after its press pulse, i.e. 2 + 1 + DB_CYCLES + 1 cycles after a stable raw edge.
REQ-026 SHALL assert param_upd for exactly one cycle, coincident with the cycle in which the new word value first appears on the output.
REQ-027 SHALL NOT assert param_upd on field changes or on ignored presses.
REQ-028 SHALL hold the word values while a key remains pressed; there is no auto-repeat.

Reset
REQ-029 SHALL, in a sys_rst-high cycle, set Fword1=F1_INIT, Fword2=F2_INIT, Pword2=P_INIT, edit_field=00 and param_upd=0.
REQ-030 SHALL, in a sys_rst-high cycle, clear all synchronizers, debounced levels and debounce counters to 0.
REQ-031 SHALL, when reset occurs mid-debounce, discard the partial count; a key held through reset SHALL produce one press pulse DB_CYCLES+2 cycles after reset release.
REQ-032 SHALL give reset priority over all key activity in the same cycle.

Verification (DB_CYCLES=4 for simulation)
REQ-033 SHALL cover: reset, then key_up held 20 cycles in EDIT_F1 -> Fword1 1->2 exactly once, with one param_upd pulse.
REQ-034 SHALL cover: key_up toggling every 2 cycles for 30 cycles (a bounce) -> no word change and no param_upd.
REQ-035 SHALL cover: sel pressed twice, then with Pword2=511 up pressed -> edit_field=10 and Pword2=0; then down pressed -> Pword2=511.
REQ-036 SHALL cover: with Fword2=0 in EDIT_F2, down pressed -> Fword2=255; up and down released-and-pressed in the same cycle -> Fword2 unchanged and no param_upd.
REQ-037 SHALL cover: sel and up made stable in the same cycle while in EDIT_F1 -> edit_field=01 with Fword1 and Fword2 unchanged.
REQ-038 SHALL cover: sys_rst asserted 2 cycles into a key_up debounce with key held -> all outputs return to init values, and exactly one increment occurs 6 cycles after reset release.
